// File: rtl/spi_reg_bank_if.sv
// Parallel register bus between the SPI controller (master) and a parameter bank (slave).
// i_DIN_VALID is a level strobe with no ready: the bank acts once on its rising edge and
// returns o_DATA_OUT for the presented address one clock later, every cycle.
interface spi_reg_bank_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 7
);
  logic [ADDR_WIDTH-1:0] i_ADDR;
  logic [DATA_WIDTH-1:0] i_DATA_IN;
  logic                  i_DIN_VALID;
  logic [DATA_WIDTH-1:0] o_DATA_OUT;

  modport master (
    output i_ADDR,
    output i_DATA_IN,
    output i_DIN_VALID,
    input  o_DATA_OUT
  );

  modport slave (
    input  i_ADDR,
    input  i_DATA_IN,
    input  i_DIN_VALID,
    output o_DATA_OUT
  );
endinterface

// File: rtl/spi_reg_bank.sv
// Shadow/active parameter register bank: SPI writes land in shadow registers and are copied
// atomically into the active set on the first audio sample tick after a COMMIT arm.
module spi_reg_bank #(
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 7,
  parameter logic [2:0]  MODULE_ID  = 3'd0,
  parameter int          NUM_REGS   = 8
) (
  input  logic                         i_CLK,
  input  logic                         i_RST_N,
  spi_reg_bank_if.slave                bus,
  input  logic                         i_SAMPLE_TICK,
  output logic [NUM_REGS*DATA_WIDTH-1:0] o_REGS,
  output logic                         o_UPDATE,
  output logic                         o_PENDING
);

  localparam int                IDX_W      = ADDR_WIDTH - 3;
  localparam logic [IDX_W-1:0]  COMMIT_IDX = {IDX_W{1'b1}};

  logic [DATA_WIDTH-1:0] shadow [NUM_REGS];
  logic [DATA_WIDTH-1:0] active [NUM_REGS];
  logic                  armed;
  logic                  dirty;
  logic                  valid_d;

  logic                  sel;
  logic [IDX_W-1:0]      idx;
  logic                  wr_fire;
  logic                  commit;
  logic [DATA_WIDTH-1:0] rd_word;

  assign sel     = (bus.i_ADDR[2:0] == MODULE_ID);
  assign idx     = bus.i_ADDR[ADDR_WIDTH-1:3];
  assign wr_fire = bus.i_DIN_VALID && !valid_d && sel;
  assign commit  = i_SAMPLE_TICK && armed;

  always_comb begin
    rd_word = '0;
    if (sel) begin
      if (idx == COMMIT_IDX) rd_word = {{(DATA_WIDTH-2){1'b0}}, armed, dirty};
      for (int k = 0; k < NUM_REGS; k++) begin
        if (idx == IDX_W'(k)) rd_word = shadow[k];
      end
    end
  end

  // The write block follows the commit block so a coincident write overrides the commit's
  // clear of dirty/armed, while the copy still sees the pre-edge shadow contents.
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        shadow[k] <= '0;
        active[k] <= '0;
      end
      armed          <= 1'b0;
      dirty          <= 1'b0;
      valid_d        <= 1'b0;
      o_UPDATE       <= 1'b0;
      bus.o_DATA_OUT <= '0;
    end else begin
      valid_d        <= bus.i_DIN_VALID;
      o_UPDATE       <= commit;
      bus.o_DATA_OUT <= rd_word;
      if (commit) begin
        for (int k = 0; k < NUM_REGS; k++) active[k] <= shadow[k];
        armed <= 1'b0;
        dirty <= 1'b0;
      end
      if (wr_fire) begin
        if (idx == COMMIT_IDX) armed <= bus.i_DATA_IN[0];
        for (int k = 0; k < NUM_REGS; k++) begin
          if (idx == IDX_W'(k)) begin
            shadow[k] <= bus.i_DATA_IN;
            dirty     <= 1'b1;
          end
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs
    assign o_REGS[k*DATA_WIDTH +: DATA_WIDTH] = active[k];
  end

  assign o_PENDING = dirty;

endmodule

// File: doc/spi_reg_bank.md
# spi_reg_bank

Parameter register bank in the system clock domain, directly downstream of the SPI controller. It decodes the controller's address and write-valid outputs and captures 32-bit words into shadow registers. On an armed commit it copies all shadow registers atomically into active registers at the next audio sample tick. It also returns the addressed word on the parallel readback path that the SPI controller shifts out on MISO.

## Interface

Parameters:
- DATA_WIDTH, 32, width of every register and of the data buses
- ADDR_WIDTH, 7, address bus width; [6:3] register index, [2:0] module select
- MODULE_ID, 3'd0, module-select value this bank answers to
- NUM_REGS, 8, number of parameter registers (1..15); index 15 is reserved for COMMIT/STATUS

Ports:
- i_CLK  in  1  system clock (same clock as the controller's i_SYSCLK)
- i_RST_N  in  1  asynchronous active-low reset
- i_ADDR  in  ADDR_WIDTH  address from the SPI controller (o_ADDR)
- i_DATA_IN  in  DATA_WIDTH  write data from the SPI controller (o_DATA_IN)
- i_DIN_VALID  in  1  write strobe from the SPI controller (o_DOUT_VALID)
- i_SAMPLE_TICK  in  1  one-cycle pulse per audio sample from the effect datapath
- o_DATA_OUT  out  DATA_WIDTH  registered readback word, wired to the controller's i_DATA_OUT
- o_REGS  out  NUM_REGS*DATA_WIDTH  active registers, flattened; register k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]
- o_UPDATE  out  1  one-cycle pulse, the cycle after active registers change
- o_PENDING  out  1  high while shadow contents differ from active contents (dirty flag)

## Operation

- Select: the bank is selected when i_ADDR[2:0] == MODULE_ID. Let idx = i_ADDR[6:3].
- Write detect:
  - A write fires on the cycle where i_DIN_VALID is 1 and its registered copy valid_d is 0 (rising edge).
  - Holding i_DIN_VALID high for several cycles produces exactly one write.
- Write to idx < NUM_REGS: shadow[idx] <= i_DATA_IN and dirty <= 1.
- Write to idx == 15 (COMMIT): armed <= i_DATA_IN[0]. Writing 0 cancels a pending arm.
- Write to any other idx (NUM_REGS..14): ignored, no state change.
- Writes with a non-matching module select are ignored.
- Commit: on a cycle with i_SAMPLE_TICK = 1 and armed = 1:
  - all active[k] <= shadow[k] as held before that edge;
  - armed <= 0 and dirty <= 0;
  - o_UPDATE = 1 during the next cycle only.
- Tick with armed = 0: no effect.
- Readback (registered, every cycle):
  - not selected -> 0, so multiple banks can be OR-combined;
  - idx < NUM_REGS -> shadow[idx];
  - idx == 15 -> {zeros, armed, dirty} (bit1 = armed, bit0 = dirty);
  - otherwise -> 0.
- o_PENDING = dirty.
- Reset (asynchronous, i_RST_N = 0): all shadow and active registers, armed, dirty, valid_d, o_UPDATE and o_DATA_OUT go to 0 immediately. Reset mid-transaction discards everything, including any pending commit.

## Timing

- Write latency: edge detected in cycle N; shadow, armed or dirty are updated at the end of cycle N and visible in cycle N+1.
- Readback latency: o_DATA_OUT reflects i_ADDR sampled one edge earlier. The controller's shift-out load happens two or more SYSCLK edges after the address completes, so the readback word is always ready in time.
- Commit latency: tick in cycle T; o_REGS changes at the end of T; o_UPDATE is high in cycle T+1.
- Simultaneous write to data register idx and commit tick:
  - the commit copies the pre-write shadow value;
  - the new value lands in shadow;
  - dirty ends at 1 (the write wins over the commit clear).
- Simultaneous COMMIT write and tick: the commit uses the old armed value. A newly armed bank commits on the next tick, not the current one.
- Back-to-back ticks: after a commit, armed = 0, so a second tick does nothing.

## Test plan

- Reset: hold i_RST_N = 0 with random inputs -> o_REGS = 0, o_DATA_OUT = 0, o_UPDATE = 0, o_PENDING = 0; release -> still 0.
- Write/readback: MODULE_ID = 2; write 0xDEADBEEF to addr {4'd3, 3'd2} -> o_PENDING = 1, readback at that addr = 0xDEADBEEF, o_REGS register 3 still 0. Same write at module 3'd5 -> no change. Hold i_DIN_VALID for 4 cycles -> exactly one write.
- Commit: write regs 0 and 1, write COMMIT = 1, pulse tick -> both registers appear in o_REGS on the same edge, o_UPDATE high exactly one cycle, STATUS reads 0. A second tick -> no o_UPDATE.
- Cancel and range: write COMMIT = 1 then COMMIT = 0, pulse tick -> no update. Write to idx 9 with NUM_REGS = 8 -> ignored, readback 0.
- Collisions: write reg 2 = 0x5 in the same cycle as an armed tick with shadow[2] = 0x1 -> active[2] = 0x1, shadow[2] = 0x5, o_PENDING = 1. COMMIT write coincident with tick -> commit occurs on the following tick.
- Async reset mid-commit: assert i_RST_N low while armed and dirty -> all state clears at once; the next tick produces no o_UPDATE.
